// File: rtl/fp_mult_operand_sequencer.sv
// Operand sequencer for the floating-point multiplier wrapper. It buffers up to DEPTH
// operand pairs, issues them one at a time, and collects the products for readback.
module fp_mult_operand_sequencer #(
  parameter  int EXP_LEN      = 8,
  parameter  int MANTISSA_LEN = 23,
  parameter  int DEPTH        = 8,
  parameter  int TIMEOUT      = 64,
  localparam int W            = 1 + EXP_LEN + MANTISSA_LEN,
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW           = $clog2(DEPTH + 1),
  localparam int TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clock,
  input  logic          reset_neg,
  input  logic          load_valid,
  input  logic [W-1:0]  load_a,
  input  logic [W-1:0]  load_b,
  output logic          load_ready,
  input  logic          start,
  output logic [W-1:0]  mult_inp_a,
  output logic [W-1:0]  mult_inp_b,
  output logic          mult_data_ready,
  input  logic          mult_product_ready,
  input  logic [W-1:0]  mult_product,
  input  logic          res_rd_en,
  input  logic [AW-1:0] res_rd_addr,
  output logic [W-1:0]  res_rd_data,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opnd_t;

  opnd_t          opnd_buf [DEPTH];
  logic [W-1:0]   res_buf  [DEPTH];

  logic [1:0]     state;
  logic [AW-1:0]  idx;
  logic [TW-1:0]  timer;

  logic           load_acc;
  logic           last_elem;
  logic           prod_acc;
  logic           timed_out;
  logic [AW-1:0]  idx_nxt;

  assign load_ready = (state == ST_IDLE) && (count < CW'(DEPTH));
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done       = (state == ST_DONE);

  // start takes priority, so a pair offered in the same cycle is discarded
  assign load_acc   = load_valid && load_ready && !start;
  assign prod_acc   = (state == ST_WAIT) && mult_product_ready;
  assign last_elem  = (CW'(idx) == (count - CW'(1)));
  assign timed_out  = (timer == TW'(TIMEOUT - 1));
  assign idx_nxt    = idx + AW'(1);

  // Storage arrays carry no reset; only control state is initialised.
  always_ff @(posedge clock) begin
    if (load_acc)
      opnd_buf[count[AW-1:0]] <= {load_a, load_b};
    if (prod_acc)
      res_buf[idx] <= mult_product;
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg)
      res_rd_data <= '0;
    else if (res_rd_en)
      res_rd_data <= res_buf[res_rd_addr];
  end

  always_ff @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      state           <= ST_IDLE;
      idx             <= '0;
      count           <= '0;
      timer           <= '0;
      mult_inp_a      <= '0;
      mult_inp_b      <= '0;
      mult_data_ready <= 1'b0;
      error           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count == '0) begin
              state <= ST_DONE;
            end else begin
              state           <= ST_ISSUE;
              idx             <= '0;
              error           <= 1'b0;
              mult_inp_a      <= opnd_buf[0].a;
              mult_inp_b      <= opnd_buf[0].b;
              mult_data_ready <= 1'b1;
            end
          end else if (load_acc) begin
            count <= count + CW'(1);
          end
        end
        ST_ISSUE: begin
          mult_data_ready <= 1'b0;
          timer           <= '0;
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          // operands stay put here; the wrapper samples them continuously
          if (mult_product_ready) begin
            if (last_elem) begin
              state <= ST_DONE;
            end else begin
              idx             <= idx_nxt;
              mult_inp_a      <= opnd_buf[idx_nxt].a;
              mult_inp_b      <= opnd_buf[idx_nxt].b;
              mult_data_ready <= 1'b1;
              state           <= ST_ISSUE;
            end
          end else if (timed_out) begin
            error <= 1'b1;
            state <= ST_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          count <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_operand_sequencer.sv
// Directed bench for fp_mult_operand_sequencer with a fixed-latency (L=6) multiplier model.
module tb_fp_mult_operand_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clock;
  logic        reset_neg;
  logic        load_valid;
  logic [31:0] load_a, load_b;
  logic        load_ready;
  logic        start;
  logic [31:0] mult_inp_a, mult_inp_b;
  logic        mult_data_ready;
  logic        mult_product_ready;
  logic [31:0] mult_product;
  logic        res_rd_en;
  logic [2:0]  res_rd_addr;
  logic [31:0] res_rd_data;
  logic [3:0]  count;
  logic        busy, done, error;

  fp_mult_operand_sequencer #(.EXP_LEN(8), .MANTISSA_LEN(23), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_neg(reset_neg),
    .load_valid(load_valid), .load_a(load_a), .load_b(load_b), .load_ready(load_ready),
    .start(start),
    .mult_inp_a(mult_inp_a), .mult_inp_b(mult_inp_b), .mult_data_ready(mult_data_ready),
    .mult_product_ready(mult_product_ready), .mult_product(mult_product),
    .res_rd_en(res_rd_en), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .count(count), .busy(busy), .done(done), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-precision multiply for normal operands (truncating), used only by the model.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) return {a[31] ^ b[31], e[7:0] + 8'd1, p[46:24]};
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  // Multiplier model: product_ready appears 6 cycles after the data_ready cycle.
  logic [5:0]  sr;
  logic [31:0] pp [6];
  logic        ready_en, spur_ready;
  logic [31:0] spur_val;

  always @(posedge clock or negedge reset_neg) begin
    if (!reset_neg) begin
      sr <= '0;
      for (int i = 0; i < 6; i++) pp[i] <= '0;
    end else begin
      sr    <= {sr[4:0], mult_data_ready};
      pp[0] <= mult_data_ready ? fp_mul(mult_inp_a, mult_inp_b) : 32'd0;
      for (int i = 1; i < 6; i++) pp[i] <= pp[i-1];
    end
  end

  assign mult_product_ready = (ready_en & sr[5]) | spur_ready;
  assign mult_product       = spur_ready ? spur_val : pp[5];

  // data_ready pulse log and back-to-back detector
  int   cyc;
  int   dr_q[$];
  int   b2b_cnt;
  logic dr_prev;
  initial begin cyc = 0; b2b_cnt = 0; dr_prev = 1'b0; end
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mult_data_ready) dr_q.push_back(cyc);
    if (mult_data_ready && dr_prev) b2b_cnt <= b2b_cnt + 1;
    dr_prev <= mult_data_ready;
  end

  int n_vec, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_pair(input logic [31:0] a, input logic [31:0] b);
    load_valid = 1'b1; load_a = a; load_b = b;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic run_batch(input int limit, output int n, output logic [31:0] a3, output logic [31:0] a10);
    start = 1'b1; n = 0; a3 = '0; a10 = '0;
    do begin
      @(negedge clock);
      start = 1'b0;
      n++;
      if (n == 3)  a3  = mult_inp_a;
      if (n == 10) a10 = mult_inp_a;
    end while (!done && n < limit);
  endtask

  task automatic rd(input int addr, output logic [31:0] d);
    res_rd_en = 1'b1; res_rd_addr = 3'(addr);
    @(negedge clock);
    res_rd_en = 1'b0;
    d = res_rd_data;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [DEPTH];
  vec_t tbl2 [2];

  initial begin
    int          n;
    logic [31:0] a3, a10, d;

    // operand table: (i+1) * 2.0 with hand-computed products
    tbl[0] = '{32'h3F800000, 32'h40000000, 32'h40000000};
    tbl[1] = '{32'h40000000, 32'h40000000, 32'h40800000};
    tbl[2] = '{32'h40400000, 32'h40000000, 32'h40C00000};
    tbl[3] = '{32'h40800000, 32'h40000000, 32'h41000000};
    tbl[4] = '{32'h40A00000, 32'h40000000, 32'h41200000};
    tbl[5] = '{32'h40C00000, 32'h40000000, 32'h41400000};
    tbl[6] = '{32'h40E00000, 32'h40000000, 32'h41600000};
    tbl[7] = '{32'h41000000, 32'h40000000, 32'h41800000};
    tbl2[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
    tbl2[1] = '{32'h3F800000, 32'hC0000000, 32'hC0000000};

    n_vec = 0; n_err = 0;
    reset_neg = 1'b0; load_valid = 1'b0; load_a = '0; load_b = '0; start = 1'b0;
    res_rd_en = 1'b0; res_rd_addr = '0; ready_en = 1'b1; spur_ready = 1'b0; spur_val = '0;
    repeat (3) @(negedge clock);
    chk("rst_load_ready", load_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_busy_done_err_dr", {busy, done, error, mult_data_ready}, 0);
    chk("rst_inp_a", mult_inp_a, 0);
    chk("rst_rd_data", res_rd_data, 0);
    reset_neg = 1'b1;
    @(negedge clock);

    // two-pair batch
    for (int i = 0; i < 2; i++) load_pair(tbl2[i].a, tbl2[i].b);
    chk("two_count", count, 2);
    dr_q.delete();
    run_batch(200, n, a3, a10);
    chk("two_latency", n, 15);
    chk("two_dr_pulses", dr_q.size(), 2);
    if (dr_q.size() == 2) chk("two_dr_spacing", dr_q[1] - dr_q[0], 7);
    chk("two_hold_a_elem0", a3, 32'h40000000);
    chk("two_hold_a_elem1", a10, 32'h3F800000);
    chk("two_error", error, 0);
    @(negedge clock);
    chk("two_count_cleared", count, 0);
    for (int i = 0; i < 2; i++) begin
      rd(i, d);
      chk($sformatf("two_res%0d", i), d, tbl2[i].exp);
    end
    res_rd_addr = 3'd0;
    @(negedge clock);
    chk("rd_data_hold", res_rd_data, tbl2[1].exp);

    // full buffer plus a dropped extra pair
    for (int i = 0; i < DEPTH; i++) load_pair(tbl[i].a, tbl[i].b);
    chk("full_load_ready", load_ready, 0);
    chk("full_count", count, DEPTH);
    load_pair(32'h12345678, 32'h12345678);
    chk("full_count_after_extra", count, DEPTH);
    run_batch(200, n, a3, a10);
    chk("full_latency", n, DEPTH * 7 + 1);
    @(negedge clock);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i, d);
      chk($sformatf("full_res%0d", i), d, tbl[i].exp);
    end

    // spurious product_ready in IDLE
    load_pair(32'h40400000, 32'h40400000);
    spur_val = 32'hDEADBEEF; spur_ready = 1'b1;
    repeat (3) @(negedge clock);
    spur_ready = 1'b0;
    chk("spur_count", count, 1);
    chk("spur_busy_done", {busy, done}, 0);
    rd(0, d);
    chk("spur_res0", d, 32'h40000000);

    // start/load_valid while busy are ignored
    start = 1'b1; n = 0;
    do begin
      @(negedge clock);
      n++;
      start = (n <= 3); load_valid = (n <= 3); load_a = 32'hDEADBEEF; load_b = 32'hDEADBEEF;
      if (n == 5) chk("busy_ignore_count", count, 1);
    end while (!done && n < 100);
    start = 1'b0; load_valid = 1'b0;
    chk("busy_ignore_latency", n, 8);
    @(negedge clock);
    rd(0, d);
    chk("busy_ignore_res0", d, 32'h41100000);
    rd(1, d);
    chk("busy_ignore_res1", d, tbl[1].exp);

    // start with empty buffer
    chk("empty_count", count, 0);
    dr_q.delete();
    run_batch(200, n, a3, a10);
    chk("empty_latency", n, 1);
    @(negedge clock);
    chk("empty_no_dr", dr_q.size(), 0);

    // timeout
    ready_en = 1'b0;
    load_pair(32'h3F800000, 32'h3F800000);
    run_batch(200, n, a3, a10);
    chk("timeout_latency", n, TIMEOUT + 2);
    chk("timeout_error", error, 1);
    @(negedge clock);
    chk("timeout_error_sticky", {error, busy}, 2'b10);
    ready_en = 1'b1;
    load_pair(32'h3F800000, 32'h40000000);
    run_batch(200, n, a3, a10);
    chk("clear_latency", n, 8);
    chk("clear_error", error, 0);
    @(negedge clock);
    rd(0, d);
    chk("clear_res0", d, 32'h40000000);

    // reset during WAIT of element 1
    for (int i = 0; i < 2; i++) load_pair(tbl2[i].a, tbl2[i].b);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("mid_busy", busy, 1);
    reset_neg = 1'b0;
    #1;
    chk("mid_rst_flags", {busy, done, error, mult_data_ready, load_ready}, 5'b00001);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_inp", {mult_inp_a, mult_inp_b}, 0);
    chk("mid_rst_rd_data", res_rd_data, 0);
    @(negedge clock);
    reset_neg = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 2; i++) load_pair(tbl2[i].a, tbl2[i].b);
    run_batch(200, n, a3, a10);
    chk("fresh_latency", n, 15);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      rd(i, d);
      chk($sformatf("fresh_res%0d", i), d, tbl2[i].exp);
    end

    chk("dr_back_to_back", b2b_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
